// File: rtl/sma_decim_fifo.sv
// Averages the upstream 4-tap moving sum (sum/4), keeps 1 of every decim+1
// averages and buffers the kept ones in a DEPTH-entry FIFO with valid/ready output.
module sma_decim_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [3:0]               decim,
    input  logic [15:0]              sum_in,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   mem_q [DEPTH];

    logic [15:0]   avg;
    logic          full;
    logic          capture;
    logic          pop;
    logic          push;
    logic          drop;

    // Output side: out_valid/out_data come only from registered state.
    // A handshake completes on a rising edge where out_valid and out_ready are both 1.
    always_comb begin
        avg       = {{2{sum_in[15]}}, sum_in[15:2]};
        full      = (level_q == FULL_LEVEL);
        out_valid = (level_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : 16'd0;
        level     = level_q;
        ovf       = ovf_q;
        pop       = out_valid & out_ready;
        capture   = en & (cnt_q == 4'd0);
        // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
        push      = capture & (~full | pop);
        drop      = capture & full & ~pop;
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        // ">=" rather than "==" so shrinking decim below cnt wraps instead of running away.
        if (en) begin
            cnt_d = (cnt_q >= decim) ? 4'd0 : cnt_q + 4'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= avg;
        end
    end

endmodule

// File: tb/tb_sma_decim_fifo.sv
// Bench for sma_decim_fifo: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_sma_decim_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  decim;
    logic [15:0] sum_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        ovf;
    logic        clr_ovf;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_q[$];

    sma_decim_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .decim     (decim),
        .sum_in    (sum_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  decim;
        logic [15:0] sum;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  el;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] d,
                                input logic [15:0] s, input logic rd, input logic c,
                                input logic ev, input logic [15:0] ed,
                                input logic [3:0] el, input logic eo);
        vec_t v;
        v.rst = r; v.en = e; v.decim = d; v.sum = s; v.rdy = rd; v.clr = c;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
        return v;
    endfunction

    function automatic logic [15:0] avg_of(input logic [15:0] s);
        logic signed [15:0] t;
        t = s;
        return t >>> 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] d,
                         input logic [15:0] s, input logic rd, input logic c);
        rst = r; en = e; decim = d; sum_in = s; out_ready = rd; clr_ovf = c;
    endtask

    // One rising edge, then settle so outputs are observed away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_expect(input string name);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check($sformatf("%s_valid%0d", name, i), {31'd0, out_valid}, 32'd1);
            check($sformatf("%s_data%0d", name, i), {16'd0, out_data}, {16'd0, e});
            drive(1'b0, 1'b0, decim, 16'd0, 1'b1, 1'b0);
            step();
        end
        check($sformatf("%s_empty_valid", name), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s_empty_data", name), {16'd0, out_data}, 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(1, 0, 0, 16'd0,     0, 0, 0, 16'd0,     0, 0));
        vecs.push_back(mk(0, 1, 0, 16'd7,     1, 0, 1, 16'd1,     1, 0));
        vecs.push_back(mk(0, 1, 0, 16'hFFFB,  1, 0, 1, 16'hFFFE,  1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h8000,  1, 0, 1, 16'hE000,  1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h7FFF,  1, 0, 1, 16'h1FFF,  1, 0));
        vecs.push_back(mk(0, 0, 0, 16'd0,     1, 0, 0, 16'd0,     0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 16'(4 * i), 0, 0, 1, 16'd1, 4'(i), 0));
        vecs.push_back(mk(0, 1, 0, 16'd36,    0, 0, 1, 16'd1,     8, 1));
        vecs.push_back(mk(0, 1, 0, 16'd40,    0, 0, 1, 16'd1,     8, 1));
        for (int j = 1; j <= 7; j++)
            vecs.push_back(mk(0, 0, 0, 16'd0, 1, 0, 1, 16'(j + 1), 4'(8 - j), 1));
        vecs.push_back(mk(0, 0, 0, 16'd0,     1, 0, 0, 16'd0,     0, 1));
        vecs.push_back(mk(0, 0, 0, 16'd0,     0, 1, 0, 16'd0,     0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 16'(4 * i), 0, 0, 1, 16'd1, 4'(i), 0));
        vecs.push_back(mk(0, 1, 0, 16'd100,   1, 0, 1, 16'd2,     8, 0));
        vecs.push_back(mk(0, 1, 0, 16'd104,   0, 1, 1, 16'd2,     8, 1));
        vecs.push_back(mk(0, 0, 0, 16'd0,     0, 1, 1, 16'd2,     8, 0));
        vecs.push_back(mk(1, 1, 0, 16'd0,     1, 0, 0, 16'd0,     0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].decim, vecs[i].sum, vecs[i].rdy, vecs[i].clr);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].ed});
            check($sformatf("vec%0d_level", i), {28'd0, level}, {28'd0, vecs[i].el});
            check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].eo});
        end

        // ---------------- mid-run reset at level 5 ----------------
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 4'd0, 16'(4 * i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
            step();
        end
        check("prerst_level", {28'd0, level}, 32'd5);
        check("prerst_ovf", {31'd0, ovf}, 32'd1);
        drive(1'b1, 1'b1, 4'd0, 16'd999, 1'b1, 1'b0);
        step();
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        drive(1'b0, 1'b1, 4'd0, 16'd44, 1'b0, 1'b0);
        step();
        check("postrst_level", {28'd0, level}, 32'd1);
        check("postrst_data", {16'd0, out_data}, 32'd11);

        // ---------------- decimation by 3, then decim lowered below cnt ----------------
        drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 4'd2, 16'(4 * k), 1'b0, 1'b0);
            step();
        end
        check("dec_level12", {28'd0, level}, 32'd4);
        drive(1'b0, 1'b1, 4'd2, 16'd200, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 4'd2, 16'd204, 1'b0, 1'b0);
        step();
        check("dec_cnt2", {28'd0, dut.cnt_q}, 32'd2);
        check("dec_level_a", {28'd0, level}, 32'd5);
        drive(1'b0, 1'b1, 4'd0, 16'd208, 1'b0, 1'b0);
        step();
        check("dec_wrap_cnt", {28'd0, dut.cnt_q}, 32'd0);
        check("dec_wrap_level", {28'd0, level}, 32'd5);
        drive(1'b0, 1'b1, 4'd0, 16'd212, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 4'd0, 16'd216, 1'b0, 1'b0);
        step();
        check("dec_level_b", {28'd0, level}, 32'd7);
        exp_q = '{16'd0, 16'd3, 16'd6, 16'd9, 16'd50, 16'd53, 16'd54};
        drain_expect("dec");

        // ---------------- en gating freezes counter ----------------
        drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 4'd3, 16'd400, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'd3, 16'(1000 + 77 * i), 1'b0, 1'b0);
            step();
            check($sformatf("engate_level%0d", i), {28'd0, level}, 32'd1);
            check($sformatf("engate_cnt%0d", i), {28'd0, dut.cnt_q}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'd3, 16'(500 + 4 * i), 1'b0, 1'b0);
            step();
            check($sformatf("engate_skip%0d", i), {28'd0, level}, 32'd1);
        end
        drive(1'b0, 1'b1, 4'd3, 16'd512, 1'b0, 1'b0);
        step();
        check("engate_cap_level", {28'd0, level}, 32'd2);
        exp_q = '{16'd100, 16'd128};
        drain_expect("engate");

        // ---------------- random stress against reference model ----------------
        begin
            int mcnt;
            logic movf;
            logic [15:0] mq[$];
            logic r, e, rd, c, cap, dropped;
            logic [3:0] d;
            logic [15:0] s;
            mcnt = 0;
            movf = 1'b0;
            d = 4'd0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                r  = (cyc == 0) || ($urandom_range(0, 199) == 0);
                e  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) d = 4'($urandom_range(0, 15));
                s  = 16'($urandom_range(0, 65535));
                rd = ($urandom_range(0, 2) == 0);
                c  = ($urandom_range(0, 19) == 0);
                drive(r, e, d, s, rd, c);
                if (r) begin
                    mq.delete();
                    mcnt = 0;
                    movf = 1'b0;
                end else begin
                    if (mq.size() > 0 && rd) void'(mq.pop_front());
                    cap = e && (mcnt == 0);
                    dropped = 1'b0;
                    if (cap) begin
                        if (mq.size() < DEPTH) mq.push_back(avg_of(s));
                        else dropped = 1'b1;
                    end
                    if (dropped) movf = 1'b1;
                    else if (c) movf = 1'b0;
                    if (e) mcnt = (mcnt >= int'(d)) ? 0 : mcnt + 1;
                end
                step();
                check("rnd_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
                check("rnd_data", {16'd0, out_data}, {16'd0, (mq.size() > 0) ? mq[0] : 16'd0});
                check("rnd_level", {28'd0, level}, 32'(mq.size()));
                check("rnd_ovf", {31'd0, ovf}, {31'd0, movf});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
